tx_frame_arbiter: RTL
=====================

# tx_frame_arbiter

Round-robin arbiter that shares the single serial transmit byte path (the `serialtx` instance behind `controller`) among up to `NREQ` independent requesters. Each requester posts one 16-bit word plus an ASCII tag byte. The block serialises the winning word as a fixed 6-byte ASCII frame: tag, four lowercase hex digits, then a space. Frames are never interleaved. The block paces the frames into `serialtx` with one-cycle `xmit` strobes, under `tx_full` back-pressure.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `clk` in 1: system clock (40 MHz).
- `reset` in 1: synchronous, active-high.
- `req` in NREQ: level request per source; held until its `ack`.
- `tag` in 8*NREQ: ASCII tag for source i, at `tag[8i+7:8i]`.
- `word` in 16*NREQ: data word for source i, at `word[16i+15:16i]`.
- `ack` out NREQ: one-cycle grant pulse; source i's tag and word were latched.
- `grant_id` out 3: index of the source whose frame is in progress or was last sent.
- `busy` out 1: high while a frame is being emitted.
- `tx_full` in 1: almost-full from the tx FIFO; must assert with ≥2 free entries.
- `xmit` out 1: one-cycle write strobe to `serialtx`.
- `txchar` out 8: byte to write; valid when `xmit`=1.

## Operation
- **States:** IDLE → TAG → HEX3 → HEX2 → HEX1 → HEX0 → TERM → IDLE.
- **Reset values:** state=IDLE, `xmit`=0, `txchar`=8'h00, `ack`=0, `busy`=0, `grant_id`=0, rr pointer=NREQ-1 (source 0 has first priority).
- **IDLE:** if any `req` bit is set:
  - search from pointer+1, wrapping modulo NREQ; the first set bit i wins;
  - latch `tag` i and `word` i into internal registers;
  - register `ack[i]`=1, `grant_id`=i, pointer=i;
  - go to TAG.
- **IDLE with no request:** stay in IDLE; all outputs 0 except `grant_id`, which holds.
- **Byte states:** on any cycle where `tx_full`=0, register `xmit`=1 and `txchar`=the state's byte, then advance. If `tx_full`=1, register `xmit`=0 and hold the state. No byte is skipped or duplicated.
- **Byte per state:**
  - TAG sends the latched tag.
  - HEXn sends nibble n of the latched word (HEX3 is [15:12], HEX0 is [3:0]).
  - TERM sends 8'h20, then returns to IDLE.
- **Hex encoding:** nibble d<10 → 8'h30+d; d≥10 → 8'h61+(d-10), i.e. lowercase a–f. This matches the `controller` input parser.
- **After grant:** the latched copy is used, so `req`, `tag` and `word` of the granted source may change freely.
- **Request handshake:** a source must drop `req` within 5 cycles after `ack`, otherwise it is re-arbitrated as a new request. A `req` dropped before `ack` is simply not granted.
- **`busy`:** equals (state≠IDLE), decoded from the state register.
- **Reset mid-frame:** the partial frame is abandoned with no further bytes. The next cycle shows the reset values. The latched word is discarded and not retried.
- **Simultaneous requests:** all are resolved by the rotating pointer. With all requests held, grant order is 0,1,…,NREQ-1,0,…
- **Fairness:** starvation-free; a held request waits at most NREQ-1 frames.

## Timing
- **Grant latency:** `req` is sampled in IDLE at cycle n; `ack` and `grant_id` are visible at n+1 (`busy`=1 from n+1).
- **First byte:** `xmit`=1 with the tag at n+2.
- **Unthrottled frame:** with `tx_full` low throughout, bytes appear on n+2 … n+7, one per cycle. `busy` falls at n+7 (IDLE).
- **Back-to-back grants:** the next grant is sampled at n+7 and acked at n+8. Minimum frame period is 7 cycles.
- **Throttling:** each `tx_full`=1 cycle in a byte state adds exactly one cycle. `xmit` is registered, so one byte may land after `tx_full` rises; this is covered by the ≥2-entry margin.
- **`ack`:** never high for more than one cycle, never for two sources at once, and never while `busy` was already high.

## Test plan
- **Single frame:**
  - stimulus: after reset, `req`=4'b0010, tag1="B", word1=16'h1a2f;
  - required: `ack`=4'b0010 for exactly one cycle at n+1;
  - required: `xmit` bytes 42,31,61,32,66,20 on n+2..n+7; `busy` high n+1..n+6.
- **Hex boundary digits:** word=16'h9a0f → hex bytes 39,61,30,66. Word=16'hffff → 66,66,66,66.
- **Round-robin order:** all four `req` held, each source dropping `req` 2 cycles after its `ack` and re-raising it 10 cycles later → grant order 0,1,2,3,0,…; `ack` one-hot; frames never interleaved.
- **Back-pressure:** `tx_full`=1 for 10 cycles starting just after the 3rd byte → no `xmit` during the stall; 4th byte follows when `tx_full` drops; frame complete, no duplicate or missing byte.
- **Reset mid-frame:** `reset` in HEX2 → next cycle `xmit`=0, `busy`=0, `ack`=0. After release, with `req[0]` and `req[2]` pending, source 0 is granted first.
- **Fairness:** `req[0]` held continuously, then `req[3]` rises → source 3 is granted at the very next IDLE decision.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter feeding 6-byte ASCII frames (tag, 4 hex digits, space)
// from NREQ requesters into a single serial transmit byte path.
module tx_frame_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    tag,
  input  logic [16*NREQ-1:0]   word,
  output logic [NREQ-1:0]      ack,
  output logic [2:0]           grant_id,
  output logic                 busy,
  input  logic                 tx_full,
  output logic                 xmit,
  output logic [7:0]           txchar
);

  typedef enum logic [2:0] {
    StIdle, StTag, StHex3, StHex2, StHex1, StHex0, StTerm
  } state_e;

  state_e          state_q, state_d, nxt_state;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            xmit_q, xmit_d;
  logic [7:0]      txchar_q, txchar_d;
  logic [7:0]      tag_q, tag_d;
  logic [15:0]     word_q, word_d;

  logic            found;
  logic [2:0]      win;
  logic [NREQ-1:0] win_oh;
  logic [7:0]      tag_sel, cur_byte;
  logic [15:0]     word_sel;

  // Lowercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
  endfunction

  // Rotating-priority search: indices above the pointer first, then wrap to the low ones.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_oh   = '0;
    tag_sel  = '0;
    word_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (3'(i) > ptr_q)) begin
        found = 1'b1;
        win   = 3'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (3'(i) <= ptr_q)) begin
        found = 1'b1;
        win   = 3'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (3'(i) == win) begin
        win_oh[i] = found;
        tag_sel   = tag[8*i +: 8];
        word_sel  = word[16*i +: 16];
      end
    end
  end

  // Byte emitted by the current byte state and the state that follows it.
  always_comb begin
    cur_byte  = 8'h00;
    nxt_state = StIdle;
    unique case (state_q)
      StTag:  begin cur_byte = tag_q;                  nxt_state = StHex3; end
      StHex3: begin cur_byte = hex_char(word_q[15:12]); nxt_state = StHex2; end
      StHex2: begin cur_byte = hex_char(word_q[11:8]);  nxt_state = StHex1; end
      StHex1: begin cur_byte = hex_char(word_q[7:4]);   nxt_state = StHex0; end
      StHex0: begin cur_byte = hex_char(word_q[3:0]);   nxt_state = StTerm; end
      StTerm: begin cur_byte = 8'h20;                   nxt_state = StIdle; end
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    ack_d    = '0;
    xmit_d   = 1'b0;
    txchar_d = txchar_q;
    tag_d    = tag_q;
    word_d   = word_q;
    if (state_q == StIdle) begin
      txchar_d = 8'h00;
      if (found) begin
        ack_d   = win_oh;
        grant_d = win;
        ptr_d   = win;
        tag_d   = tag_sel;
        word_d  = word_sel;
        state_d = StTag;
      end
    end else if (!tx_full) begin
      xmit_d   = 1'b1;
      txchar_d = cur_byte;
      state_d  = nxt_state;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= 3'(NREQ - 1);
      grant_q  <= '0;
      ack_q    <= '0;
      xmit_q   <= 1'b0;
      txchar_q <= 8'h00;
      tag_q    <= 8'h00;
      word_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      xmit_q   <= xmit_d;
      txchar_q <= txchar_d;
      tag_q    <= tag_d;
      word_q   <= word_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);
  assign xmit     = xmit_q;
  assign txchar   = txchar_q;

endmodule
